reorder_buffer_param: RTL and testbench

// Parametrised in-order-retire reorder buffer for the out-of-order core. Sits between decoder/issue (append),
// the RS/LSB/ALU writeback buses, and the register file, branch predictor, return-address stack and LSB (commit).

---
 rtl/reorder_buffer_param.sv | 193 +++++++++++++++++++
 tb/tb_reorder_buffer_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_param.sv
// Parametrised in-order-retire reorder buffer: allocates at tail, collects
// writebacks, retires one entry per cycle to regfile/predictor/RAS/LSB.
module reorder_buffer_param #(
  parameter int DEPTH    = 32,
  parameter int WB_PORTS = 3,
  parameter int XLEN     = 32,
  parameter int AW       = 17,
  localparam int IDW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     append_en,
  input  logic [2:0]               append_type,
  input  logic [4:0]               append_dest_regid,
  input  logic [AW-1:0]            append_address_info,
  input  logic [AW-1:0]            append_address_predict,
  input  logic [AW-1:0]            append_address,
  input  logic                     append_branch_prediction,
  input  logic [WB_PORTS-1:0]      wb_en,
  input  logic [WB_PORTS*IDW-1:0]  wb_vregid,
  input  logic [WB_PORTS*XLEN-1:0] wb_val,
  input  logic [IDW-1:0]           query_vregid,
  output logic                     query_dependency,
  output logic [XLEN-1:0]          query_val,
  input  logic                     store_ready,
  output logic                     commit_en,
  output logic                     register_writeback_en,
  output logic [4:0]               register_writeback_id,
  output logic [XLEN-1:0]          register_writeback_val,
  output logic                     predictor_input_en,
  output logic [AW-1:0]            predictor_addr,
  output logic                     branch_take,
  output logic                     stack_input_en,
  output logic                     stack_push_mode,
  output logic [AW-1:0]            stack_push_addr,
  output logic                     reset_en,
  output logic [AW-1:0]            reset_new_pc,
  output logic [IDW-1:0]           next_id,
  output logic                     full,
  output logic                     empty,
  output logic [IDW:0]             count
);

  localparam logic [2:0] T_ALU  = 3'd0;
  localparam logic [2:0] T_ST   = 3'd1;
  localparam logic [2:0] T_BR   = 3'd2;
  localparam logic [2:0] T_JAL  = 3'd3;
  localparam logic [2:0] T_JALR = 3'd4;
  localparam logic [IDW:0] CAP  = (IDW+1)'(DEPTH);
  localparam logic [IDW:0] HI   = (IDW+1)'(DEPTH-1);

  logic            e_rdy  [DEPTH];
  logic [2:0]      e_type [DEPTH];
  logic [4:0]      e_rd   [DEPTH];
  logic [AW-1:0]   e_info [DEPTH];
  logic [AW-1:0]   e_ppc  [DEPTH];
  logic [AW-1:0]   e_pc   [DEPTH];
  logic            e_pred [DEPTH];
  logic [XLEN-1:0] e_val  [DEPTH];

  logic [IDW-1:0]  head, tail, tail_next;
  logic            flush, do_app, do_ret;
  logic [IDW:0]    count_next;
  logic [IDW-1:0]  wid   [WB_PORTS];
  logic [XLEN-1:0] wv    [WB_PORTS];
  logic            wjalr [WB_PORTS];
  logic            whit  [WB_PORTS];

  assign flush      = rst | reset_en;
  assign do_app     = append_en & (count != CAP);
  assign do_ret     = ~empty & e_rdy[head] &
                      ((e_type[head] != T_ST) | store_ready);
  assign tail_next  = tail + IDW'(do_app);
  assign count_next = count + (IDW+1)'(do_app) - (IDW+1)'(do_ret);

  // jalr target check must see the type/prediction of an entry appended this cycle
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wid[p] = wb_vregid[p*IDW +: IDW];
      wv[p]  = wb_val[p*XLEN +: XLEN];
      if (do_app && tail == wid[p]) begin
        wjalr[p] = append_type == T_JALR;
        whit[p]  = wv[p][AW-1:0] == append_address_predict;
      end else begin
        wjalr[p] = e_type[wid[p]] == T_JALR;
        whit[p]  = wv[p][AW-1:0] == e_ppc[wid[p]];
      end
    end
  end

  always_comb begin
    query_dependency = 1'b1;
    query_val        = '0;
    if (e_rdy[query_vregid]) begin
      query_dependency = 1'b0;
      query_val = (e_type[query_vregid] == T_JAL) ?
                  XLEN'(e_info[query_vregid]) : e_val[query_vregid];
    end else begin
      for (int p = WB_PORTS-1; p >= 0; p--) begin
        if (wb_en[p] && wid[p] == query_vregid) begin
          query_dependency = 1'b0;
          query_val        = wv[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_app) begin
        e_rdy[tail]  <= (append_type == T_ST) | (append_type == T_JAL);
        e_type[tail] <= append_type;
        e_rd[tail]   <= append_dest_regid;
        e_info[tail] <= append_address_info;
        e_ppc[tail]  <= append_address_predict;
        e_pc[tail]   <= append_address;
        e_pred[tail] <= append_branch_prediction;
      end
      // descending loop: the lowest port's assignment lands last and wins
      for (int p = WB_PORTS-1; p >= 0; p--) begin
        if (wb_en[p]) begin
          e_rdy[wid[p]] <= 1'b1;
          e_val[wid[p]] <= wv[p];
          if (wjalr[p]) e_pred[wid[p]] <= whit[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    register_writeback_en <= 1'b0;
    commit_en             <= 1'b0;
    predictor_input_en    <= 1'b0;
    stack_input_en        <= 1'b0;
    reset_en              <= 1'b0;
    if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      next_id <= '0;
    end else begin
      tail    <= tail_next;
      count   <= count_next;
      empty   <= count_next == '0;
      full    <= count_next >= HI;
      next_id <= tail_next;
      if (do_ret) begin
        head <= head + 1'b1;
        unique case (e_type[head])
          T_ALU: begin
            register_writeback_en  <= 1'b1;
            register_writeback_id  <= e_rd[head];
            register_writeback_val <= e_val[head];
          end
          T_ST: commit_en <= 1'b1;
          T_BR: begin
            predictor_input_en <= 1'b1;
            predictor_addr     <= e_pc[head];
            branch_take        <= e_val[head][0];
            if (e_val[head][0] != e_pred[head]) begin
              reset_en     <= 1'b1;
              reset_new_pc <= e_info[head];
            end
          end
          T_JAL: begin
            register_writeback_en  <= 1'b1;
            register_writeback_id  <= e_rd[head];
            register_writeback_val <= XLEN'(e_info[head]);
            stack_input_en         <= 1'b1;
            stack_push_mode        <= 1'b1;
            stack_push_addr        <= e_info[head];
          end
          T_JALR: begin
            register_writeback_en  <= 1'b1;
            register_writeback_id  <= e_rd[head];
            register_writeback_val <= XLEN'(e_info[head]);
            stack_input_en         <= 1'b1;
            stack_push_mode        <= 1'b0;
            stack_push_addr        <= e_info[head];
            if (!e_pred[head]) begin
              reset_en     <= 1'b1;
              reset_new_pc <= e_val[head][AW-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_param.sv
// Bench for reorder_buffer_param: directed cycle table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_reorder_buffer_param;
  localparam int DEPTH = 8, WBP = 3, XLEN = 32, AW = 17, IDW = 3;

  logic clk = 1'b0;
  logic rst, append_en, append_branch_prediction, store_ready;
  logic [2:0] append_type;
  logic [4:0] append_dest_regid;
  logic [AW-1:0] append_address_info, append_address_predict, append_address;
  logic [WBP-1:0] wb_en;
  logic [WBP*IDW-1:0] wb_vregid;
  logic [WBP*XLEN-1:0] wb_val;
  logic [IDW-1:0] query_vregid;
  logic query_dependency, commit_en, register_writeback_en;
  logic [XLEN-1:0] query_val, register_writeback_val;
  logic [4:0] register_writeback_id;
  logic predictor_input_en, branch_take, stack_input_en, stack_push_mode;
  logic reset_en, full, empty;
  logic [AW-1:0] predictor_addr, stack_push_addr, reset_new_pc;
  logic [IDW-1:0] next_id;
  logic [IDW:0] count;

  always #5 clk = ~clk;

  reorder_buffer_param #(.DEPTH(DEPTH), .WB_PORTS(WBP), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .append_en(append_en), .append_type(append_type),
    .append_dest_regid(append_dest_regid),
    .append_address_info(append_address_info),
    .append_address_predict(append_address_predict),
    .append_address(append_address),
    .append_branch_prediction(append_branch_prediction),
    .wb_en(wb_en), .wb_vregid(wb_vregid), .wb_val(wb_val),
    .query_vregid(query_vregid), .query_dependency(query_dependency),
    .query_val(query_val), .store_ready(store_ready), .commit_en(commit_en),
    .register_writeback_en(register_writeback_en),
    .register_writeback_id(register_writeback_id),
    .register_writeback_val(register_writeback_val),
    .predictor_input_en(predictor_input_en), .predictor_addr(predictor_addr),
    .branch_take(branch_take), .stack_input_en(stack_input_en),
    .stack_push_mode(stack_push_mode), .stack_push_addr(stack_push_addr),
    .reset_en(reset_en), .reset_new_pc(reset_new_pc),
    .next_id(next_id), .full(full), .empty(empty), .count(count)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic idle();
    rst = 0; append_en = 0; append_type = 0; append_dest_regid = 0;
    append_address_info = 0; append_address_predict = 0; append_address = 0;
    append_branch_prediction = 0; wb_en = 0; wb_vregid = 0; wb_val = 0;
    query_vregid = 0; store_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1; tick();
  endtask

  // one row = one cycle of inputs and the outputs required after its edge
  typedef struct {
    logic r, ae; logic [2:0] at; logic [4:0] rd;
    logic [AW-1:0] info, ppc; logic bp;
    logic wen; logic [1:0] wp; logic [IDW-1:0] wid; logic [XLEN-1:0] wv;
    logic sr;
    logic [4:0] eo; logic [1:0] ex; logic [4:0] erd;
    logic [XLEN-1:0] ev; logic [AW-1:0] epc;
    logic [3:0] ecnt; logic [IDW-1:0] enid;
  } vec_t;
  vec_t tv[18];

  typedef struct {
    logic [IDW-1:0] id; logic [2:0] t; logic [4:0] rd;
    logic [AW-1:0] info, ppc, pc; logic bp, rdy, pr; logic [XLEN-1:0] val;
  } ent_t;
  ent_t q[$];
  int mtail = 0;
  logic m_flush = 0;
  logic e_rw, e_cm, e_pe, e_se, e_re, e_bt, e_sm;
  logic [4:0] e_rwid;
  logic [XLEN-1:0] e_rwval;
  logic [AW-1:0] e_pa, e_sa, e_rpc;

  task automatic model_edge();
    ent_t h, n;
    bit ret;
    {e_rw, e_cm, e_pe, e_se, e_re} = '0;
    if (rst || m_flush) begin
      q.delete(); mtail = 0; m_flush = 0;
      return;
    end
    ret = q.size() > 0 && q[0].rdy && (q[0].t != 1 || store_ready);
    if (ret) begin
      h = q[0];
      case (h.t)
        0: begin e_rw = 1; e_rwid = h.rd; e_rwval = h.val; end
        1: e_cm = 1;
        2: begin
          e_pe = 1; e_pa = h.pc; e_bt = h.val[0];
          if (h.val[0] != h.bp) begin e_re = 1; e_rpc = h.info; end
        end
        3: begin
          e_rw = 1; e_rwid = h.rd; e_rwval = XLEN'(h.info);
          e_se = 1; e_sm = 1; e_sa = h.info;
        end
        default: begin
          e_rw = 1; e_rwid = h.rd; e_rwval = XLEN'(h.info);
          e_se = 1; e_sm = 0;
          if (!h.pr) begin e_re = 1; e_rpc = h.val[AW-1:0]; end
        end
      endcase
    end
    for (int p = WBP-1; p >= 0; p--)
      if (wb_en[p])
        foreach (q[i])
          if (q[i].id == wb_vregid[p*IDW +: IDW]) begin
            q[i].rdy = 1;
            q[i].val = wb_val[p*XLEN +: XLEN];
            if (q[i].t == 4) q[i].pr = (q[i].val[AW-1:0] == q[i].ppc);
          end
    if (append_en && q.size() < DEPTH) begin
      n.id = IDW'(mtail); n.t = append_type; n.rd = append_dest_regid;
      n.info = append_address_info; n.ppc = append_address_predict;
      n.pc = append_address; n.bp = append_branch_prediction;
      n.rdy = (append_type == 1 || append_type == 3);
      n.pr = append_branch_prediction; n.val = '0;
      q.push_back(n);
      mtail = (mtail + 1) % DEPTH;
    end
    if (ret) q.delete(0);
    m_flush = e_re;
  endtask

  task automatic rand_drive();
    int cand[$];
    int k;
    logic [XLEN-1:0] v;
    idle();
    rst = ($urandom_range(0, 99) == 0);
    append_en = ($urandom_range(0, 99) < 60) && q.size() < DEPTH;
    append_type = 3'($urandom_range(0, 4));
    append_dest_regid = 5'($urandom);
    append_address_info = AW'($urandom);
    append_address_predict = AW'($urandom);
    append_address = AW'($urandom);
    append_branch_prediction = 1'($urandom);
    store_ready = ($urandom_range(0, 3) != 0);
    foreach (q[i]) if (!q[i].rdy) cand.push_back(i);
    for (int p = 0; p < WBP; p++) begin
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = cand[$urandom_range(0, cand.size()-1)];
        v = $urandom;
        if (q[k].t == 2) v[0] = ($urandom_range(0, 3) != 0) ? q[k].bp : ~q[k].bp;
        if (q[k].t == 4 && $urandom_range(0, 1) == 1) v[AW-1:0] = q[k].ppc;
        wb_en[p] = 1;
        wb_vregid[p*IDW +: IDW] = q[k].id;
        wb_val[p*XLEN +: XLEN] = v;
      end
    end
  endtask

  task automatic rand_query();
    int k;
    logic dep;
    logic [XLEN-1:0] val;
    if (q.size() == 0) return;
    k = $urandom_range(0, q.size()-1);
    query_vregid = q[k].id;
    #1;
    dep = 1; val = '0;
    if (q[k].rdy) begin
      dep = 0;
      val = (q[k].t == 3) ? XLEN'(q[k].info) : q[k].val;
    end else
      for (int p = WBP-1; p >= 0; p--)
        if (wb_en[p] && wb_vregid[p*IDW +: IDW] == q[k].id) begin
          dep = 0; val = wb_val[p*XLEN +: XLEN];
        end
    chk("rq_dep", query_dependency, dep);
    if (!(q[k].rdy && q[k].t == 1)) chk("rq_val", query_val, val);
  endtask

  task automatic rand_check();
    chk("r_en", {register_writeback_en, commit_en, predictor_input_en,
                 stack_input_en, reset_en}, {e_rw, e_cm, e_pe, e_se, e_re});
    if (e_rw) chk("r_rw", {register_writeback_id, register_writeback_val}, {e_rwid, e_rwval});
    if (e_pe) chk("r_pred", {predictor_addr, branch_take}, {e_pa, e_bt});
    if (e_se) chk("r_ras_mode", stack_push_mode, e_sm);
    if (e_se && e_sm) chk("r_ras_addr", stack_push_addr, e_sa);
    if (e_re) chk("r_newpc", reset_new_pc, e_rpc);
    chk("r_count", count, q.size());
    chk("r_empty", empty, q.size() == 0);
    chk("r_full", full, q.size() >= DEPTH-1);
    chk("r_next_id", next_id, mtail);
  endtask

  initial begin
    idle();
    //        r ae at rd info    ppc  bp wen wp wid wv       sr  eo        ex erd ev      epc   cnt nid
    tv[0]  = '{1, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     0, 0};
    tv[1]  = '{0, 1, 0, 5, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     1, 1};
    tv[2]  = '{0, 0, 0, 0, 0,      0,    0, 1, 1, 0, 'h1234, 1, 5'b00000, 0, 0, 0,      0,     1, 1};
    tv[3]  = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b10000, 0, 5, 'h1234, 0,     0, 1};
    tv[4]  = '{0, 1, 1, 0, 0,      0,    0, 0, 0, 0, 0,      0, 5'b00000, 0, 0, 0,      0,     1, 2};
    tv[5]  = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      0, 5'b00000, 0, 0, 0,      0,     1, 2};
    tv[6]  = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      0, 5'b00000, 0, 0, 0,      0,     1, 2};
    tv[7]  = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b01000, 0, 0, 0,      0,     0, 2};
    tv[8]  = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     0, 2};
    tv[9]  = '{0, 1, 2, 0, 'h100,  0,    1, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     1, 3};
    tv[10] = '{0, 0, 0, 0, 0,      0,    0, 1, 0, 2, 0,      1, 5'b00000, 0, 0, 0,      0,     1, 3};
    tv[11] = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00101, 0, 0, 0,      'h100, 0, 3};
    tv[12] = '{0, 1, 0, 3, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     0, 0};
    tv[13] = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     0, 0};
    tv[14] = '{0, 1, 4, 1, 'h44,   'h200, 0, 0, 0, 0, 0,     1, 5'b00000, 0, 0, 0,      0,     1, 1};
    tv[15] = '{0, 0, 0, 0, 0,      0,    0, 1, 2, 0, 'h204,  1, 5'b00000, 0, 0, 0,      0,     1, 1};
    tv[16] = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b10011, 0, 1, 'h44,   'h204, 0, 1};
    tv[17] = '{0, 0, 0, 0, 0,      0,    0, 0, 0, 0, 0,      1, 5'b00000, 0, 0, 0,      0,     0, 0};

    foreach (tv[i]) begin
      @(negedge clk);
      idle();
      rst = tv[i].r; append_en = tv[i].ae; append_type = tv[i].at;
      append_dest_regid = tv[i].rd; append_address_info = tv[i].info;
      append_address_predict = tv[i].ppc; append_address = 17'h40;
      append_branch_prediction = tv[i].bp; store_ready = tv[i].sr;
      if (tv[i].wen) begin
        wb_en[tv[i].wp] = 1'b1;
        wb_vregid[tv[i].wp*IDW +: IDW] = tv[i].wid;
        wb_val[tv[i].wp*XLEN +: XLEN] = tv[i].wv;
      end
      tick();
      chk($sformatf("v%0d_en", i), {register_writeback_en, commit_en,
          predictor_input_en, stack_input_en, reset_en}, tv[i].eo);
      if (tv[i].eo[4]) chk($sformatf("v%0d_rw", i),
          {register_writeback_id, register_writeback_val}, {tv[i].erd, tv[i].ev});
      if (tv[i].eo[2]) chk($sformatf("v%0d_take", i), branch_take, tv[i].ex[1]);
      if (tv[i].eo[1]) chk($sformatf("v%0d_ras", i), stack_push_mode, tv[i].ex[0]);
      if (tv[i].eo[0]) chk($sformatf("v%0d_newpc", i), reset_new_pc, tv[i].epc);
      chk($sformatf("v%0d_count", i), count, tv[i].ecnt);
      chk($sformatf("v%0d_empty", i), empty, tv[i].ecnt == 0);
      chk($sformatf("v%0d_full", i), full, tv[i].ecnt >= DEPTH-1);
      chk($sformatf("v%0d_next_id", i), next_id, tv[i].enid);
    end

    // fill to the slack threshold, retire one, then wrap next_id
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); idle(); append_en = 1; append_dest_regid = 5'(i);
      tick();
      if (i == 5) chk("fill_full6", full, 0);
    end
    chk("fill_full7", full, 1);
    chk("fill_count7", count, 7);
    chk("fill_nid7", next_id, 7);
    @(negedge clk); idle(); wb_en[0] = 1; wb_val[31:0] = 32'h55; tick();
    @(negedge clk); idle(); tick();
    chk("fill_retire", {register_writeback_en, register_writeback_id}, {1'b1, 5'd0});
    chk("fill_full_drop", full, 0);
    chk("fill_count6", count, 6);
    @(negedge clk); idle(); append_en = 1; tick();
    chk("fill_wrap", next_id, 0);
    chk("fill_count_back", count, 7);

    // lowest writeback port wins for both bypass and stored value
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); append_en = 1; tick();
    end
    @(negedge clk); idle();
    wb_en = 3'b101;
    wb_vregid = {3'd2, 3'd0, 3'd2};
    wb_val = {32'hB, 32'h0, 32'hA};
    query_vregid = 2;
    #1;
    chk("prio_bypass_dep", query_dependency, 0);
    chk("prio_bypass_val", query_val, 32'hA);
    tick();
    @(negedge clk); idle(); query_vregid = 2; #1;
    chk("prio_stored_dep", query_dependency, 0);
    chk("prio_stored_val", query_val, 32'hA);
    @(negedge clk); idle(); query_vregid = 1; #1;
    chk("pend_dep", {query_dependency, query_val}, {1'b1, 32'h0});

    do_reset();
    q.delete(); mtail = 0; m_flush = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_drive();
      rand_query();
      model_edge();
      tick();
      rand_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
